// File: rtl/acumulador_saturado.sv
// acumulador_saturado: sums COUNT signed samples and strobes the result; define ACUMULADOR_SATURATION_EN to clamp on overflow instead of wrapping.
module acumulador_saturado #(
  parameter int N = 32,
  parameter int COUNT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_load,
  output logic         overflow,
  output logic         busy
);
  localparam int CW = $clog2(COUNT + 1);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, EMIT = 2'd2;
  logic [1:0] state;
  logic [N-1:0] acc;
  logic [CW-1:0] cnt;
  logic ovf_int;
  logic accept;
  logic [N:0] sum;
  logic sum_ovf;
  logic [N-1:0] sum_n;
  assign in_ready = !reset && state != EMIT;
  assign busy = state != IDLE;
  assign accept = in_valid && in_ready;
  assign sum = {acc[N-1], acc} + {in_data[N-1], in_data};
  assign sum_ovf = sum[N] ^ sum[N-1];
`ifdef ACUMULADOR_SATURATION_EN
  // the extra sign bit tells which rail was crossed
  assign sum_n = !sum_ovf ? sum[N-1:0] : sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
  assign sum_n = sum[N-1:0];
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf_int <= 1'b0;
      out_data <= '0;
      overflow <= 1'b0;
      out_load <= 1'b0;
    end else begin
      out_load <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          acc <= in_data;
          cnt <= CW'(1);
          ovf_int <= 1'b0;
          state <= COUNT == 1 ? EMIT : ACCUM;
        end
        ACCUM: if (accept) begin
          acc <= sum_n;
          cnt <= cnt + 1'b1;
          ovf_int <= ovf_int | sum_ovf;
          if (cnt == CW'(COUNT - 1)) state <= EMIT;
        end
        EMIT: begin
          out_data <= acc;
          overflow <= ovf_int;
          out_load <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acumulador_saturado.sv
// tb_acumulador_saturado: directed and random groups against an arithmetic reference model.
module tb_acumulador_saturado;
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] in_data = '0, out_data;
  logic in_valid = 1'b0, in_ready, out_load, overflow, busy;
  logic [7:0] d1 = '0, o1;
  logic v1 = 1'b0, r1, l1, ov1, b1;
  int checks = 0, failures = 0;
  int exp_d[$];
  int exp_o[$];
  bit prev_ready = 1'b0;
  always #5 clock = ~clock;
  acumulador_saturado #(.N(8), .COUNT(4)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_load(out_load), .overflow(overflow), .busy(busy));
  acumulador_saturado #(.N(8), .COUNT(1)) dut1 (
    .clock(clock), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(r1),
    .out_data(o1), .out_load(l1), .overflow(ov1), .busy(b1));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // Each result is checked when its strobe appears; the cycle before must have been the bubble.
  always @(negedge clock) begin
    if (out_load) begin
      chk("emit_ready", int'(prev_ready), 0);
      if (exp_d.size() == 0) chk("spurious_load", 1, 0);
      else begin
        chk("out_data", int'($signed(out_data)), exp_d.pop_front());
        chk("overflow", int'(overflow), exp_o.pop_front());
      end
    end
    prev_ready = in_ready;
  end
  function automatic void model(input int s[4], output int d, output int o);
    d = s[0];
    o = 0;
    for (int i = 1; i < 4; i++) begin
      int t;
      t = d + s[i];
      if (t > 127 || t < -128) begin
        o = 1;
`ifdef ACUMULADOR_SATURATION_EN
        t = t > 127 ? 127 : -128;
`else
        t = t > 127 ? t - 256 : t + 256;
`endif
      end
      d = t;
    end
  endfunction
  task automatic send(input int v);
    int w = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data = 8'(v);
    while (!in_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask
  task automatic group(input int s[4], input int gap, input int ed, input int eo);
    for (int k = 0; k < 3; k++) begin
      send(s[k]);
      repeat (gap) begin
        @(negedge clock);
        chk("busy_gap", int'(busy), 1);
      end
    end
    send(s[3]);
    chk("emit_in_ready", int'(in_ready), 0);
    chk("emit_busy", int'(busy), 1);
    chk("emit_no_load", int'(out_load), 0);
    exp_d.push_back(ed);
    exp_o.push_back(eo);
    @(posedge clock);
    #1 chk("load_latency", int'(out_load), 1);
  endtask
  initial begin
    int g[4];
    int ed, eo;
    in_valid = 1'b1;
    in_data = 8'd99;
    v1 = 1'b1;
    d1 = 8'd99;
    @(posedge clock);
    #1 chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_load", int'(out_load), 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    v1 = 1'b0;
    #1 chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_busy1", int'(b1), 0);
    @(negedge clock);
    v1 = 1'b1;
    d1 = 8'd7;
    #1 chk("c1_ready_a", int'(r1), 1);
    @(posedge clock);
    #1 chk("c1_ready_b", int'(r1), 0);
    chk("c1_load_b", int'(l1), 0);
    d1 = 8'(-3);
    @(posedge clock);
    #1 chk("c1_load_c", int'(l1), 1);
    chk("c1_data_c", int'($signed(o1)), 7);
    chk("c1_ready_c", int'(r1), 1);
    @(posedge clock);
    #1 chk("c1_ready_d", int'(r1), 0);
    chk("c1_load_d", int'(l1), 0);
    v1 = 1'b0;
    @(posedge clock);
    #1 chk("c1_load_e", int'(l1), 1);
    chk("c1_data_e", int'($signed(o1)), -3);
    @(posedge clock);
    #1 chk("c1_load_f", int'(l1), 0);
    chk("c1_hold", int'($signed(o1)), -3);
    g = '{10, 20, -5, 3};
    group(g, 0, 28, 0);
    g = '{100, 100, 0, 0};
`ifdef ACUMULADOR_SATURATION_EN
    group(g, 0, 127, 1);
`else
    group(g, 0, -56, 1);
`endif
    g = '{-128, -1, 1, 0};
`ifdef ACUMULADOR_SATURATION_EN
    group(g, 1, -127, 1);
`else
    group(g, 1, -128, 1);
`endif
    g = '{1, 2, 3, 4};
    group(g, 3, 10, 0);
    @(posedge clock);
    #1 chk("load_one_cycle", int'(out_load), 0);
    chk("hold_data", int'($signed(out_data)), 10);
    send(1);
    send(2);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("abort_ready", int'(in_ready), 0);
    @(posedge clock);
    #1 chk("abort_data", int'(out_data), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_load", int'(out_load), 0);
    @(negedge clock);
    reset = 1'b0;
    g = '{5, 5, 5, 5};
    group(g, 0, 20, 0);
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 4; k++)
        g[k] = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 127 : -128) : int'($urandom_range(0, 255)) - 128;
      model(g, ed, eo);
      group(g, int'($urandom_range(0, 2)), ed, eo);
    end
    repeat (3) @(negedge clock);
    chk("pending", exp_d.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
endmodule
